// File: rtl/demux_2b.sv
// demux_2b: 1-to-2 four-phase handshake demux; routes req_in to req_out[sel], relays ack back upstream.
// Latency: 1 cycle per handshake edge, or 1+SYNC_STAGES cycles when DEMUX_SYNC_EN is defined.
// Backpressure: a transaction holds its channel until the 4-phase cycle completes; new requests only from IDLE.
module demux_2b #(
    parameter int SYNC_STAGES = 2,  // 2..4, used only when DEMUX_SYNC_EN is defined
    parameter int TIMEOUT     = 0   // cycles in REQ before err sets; 0 disables the watchdog
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_in,
    input  logic       sel,
    output logic       ack_in,
    output logic [1:0] req_out,
    input  logic [1:0] ack_out,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2,
        S_RTZ  = 2'd3
    } state_t;

    logic       r_req;
    logic [1:0] r_ack;

`ifdef DEMUX_SYNC_EN
    logic [SYNC_STAGES-1:0]      req_sync_q, req_sync_d;
    logic [SYNC_STAGES-1:0][1:0] ack_sync_q, ack_sync_d;

    // Shift raw inputs one stage deeper into the synchronizer chains each cycle.
    always_comb begin
        req_sync_d = {req_sync_q[SYNC_STAGES-2:0], req_in};
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_out};
    end

    // Synchronizer flops; cleared on reset so a stale request cannot leak through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_q <= '0;
            ack_sync_q <= '0;
        end else begin
            req_sync_q <= req_sync_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    // FSM sees only the last stage of each chain.
    always_comb begin
        r_req = req_sync_q[SYNC_STAGES-1];
        r_ack = ack_sync_q[SYNC_STAGES-1];
    end
`else
    // Environment is synchronous to clk, so inputs feed the FSM directly.
    always_comb begin
        r_req = req_in;
        r_ack = ack_out;
    end
`endif

    state_t     state_q, state_d;
    logic       k_q, k_d;
    logic       ack_in_q, ack_in_d;
    logic [1:0] req_out_q, req_out_d;

    // Handshake FSM: the channel k latched at IDLE exit owns the whole transaction,
    // so later sel changes and the other channel's ack are never looked at.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        ack_in_d  = ack_in_q;
        req_out_d = req_out_q;
        case (state_q)
            S_IDLE: begin
                if (r_req) begin
                    k_d       = sel;
                    req_out_d = sel ? 2'b10 : 2'b01;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (r_ack[k_q]) begin
                    ack_in_d = 1'b1;
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                if (!r_req) begin
                    req_out_d = 2'b00;
                    state_d   = S_RTZ;
                end
            end
            S_RTZ: begin
                if (!r_ack[k_q]) begin
                    ack_in_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                ack_in_d  = 1'b0;
                req_out_d = 2'b00;
            end
        endcase
    end

    // FSM and registered handshake outputs; reset abandons any partial handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= 1'b0;
            ack_in_q  <= 1'b0;
            req_out_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            ack_in_q  <= ack_in_d;
            req_out_q <= req_out_d;
        end
    end

    assign ack_in  = ack_in_q;
    assign req_out = req_out_q;
    assign busy    = (state_q != S_IDLE);

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int            CW   = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          err_q, err_d;

            // Count cycles spent waiting in REQ; saturate at TMAX and latch err sticky.
            always_comb begin
                cnt_d = cnt_q;
                err_d = err_q;
                if (state_q == S_IDLE && r_req) begin
                    cnt_d = '0;
                end else if (state_q == S_REQ) begin
                    if (cnt_q != TMAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_d == TMAX) begin
                        err_d = 1'b1;
                    end
                end
            end

            // Watchdog state; only reset clears err.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    err_q <= err_d;
                end
            end

            assign err = err_q;
        end else begin : g_no_wdog
            assign err = 1'b0;
        end
    endgenerate

endmodule
